// File: rtl/tiq_therm_encoder_if.sv
// Result handshake between the TIQ thermometer encoder and the readout logic.
// The master drives result/result_valid; the slave answers with result_ready.
interface tiq_therm_encoder_if #(
    parameter int RES_W = 6
);
    logic [RES_W-1:0] result;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output result,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  result,
        input  result_valid,
        output result_ready
    );
endinterface

// File: rtl/tiq_therm_encoder.sv
// TIQ flash-ADC back-end: synchronise the thermometer code, encode it and sum 2^AVG_LOG2 samples.
// Define TIQ_BUBBLE_CORR_EN to add a registered 3-input majority bubble filter (one extra cycle of latency).
module tiq_therm_encoder #(
    parameter int N_LEVELS   = 15,
    parameter int OUT_W      = 4,
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LEVELS-1:0] therm_in,
    input  logic                start,
    input  logic                continuous,
    tiq_therm_encoder_if.master res,
    output logic                busy,
    output logic                overrun
);
    localparam int RES_W = OUT_W + AVG_LOG2;
    localparam int N_ACC = 1 << AVG_LOG2;
`ifdef TIQ_BUBBLE_CORR_EN
    localparam int SETTLE_LEN = SETTLE_CYC + 1;
`else
    localparam int SETTLE_LEN = SETTLE_CYC;
`endif
    localparam int CNT_MAX = (SETTLE_LEN > N_ACC) ? SETTLE_LEN : N_ACC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    // Two-flop synchroniser; therm_in is asynchronous to clk.
    logic [N_LEVELS-1:0] sync_meta_reg;
    logic [N_LEVELS-1:0] therm_s_reg;
    logic [N_LEVELS-1:0] filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_reg <= '0;
            therm_s_reg   <= '0;
        end else begin
            sync_meta_reg <= therm_in;
            therm_s_reg   <= sync_meta_reg;
        end
    end

`ifdef TIQ_BUBBLE_CORR_EN
    // Edge padding: below the lowest comparator reads 1, above the highest reads 0.
    logic [N_LEVELS+1:0] therm_ext;
    logic [N_LEVELS-1:0] maj;
    logic [N_LEVELS-1:0] filt_reg;

    assign therm_ext = {1'b0, therm_s_reg, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < N_LEVELS; gi++) begin : g_majority
            assign maj[gi] = (therm_ext[gi]   & therm_ext[gi+1]) |
                             (therm_ext[gi]   & therm_ext[gi+2]) |
                             (therm_ext[gi+1] & therm_ext[gi+2]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_reg <= '0;
        end else begin
            filt_reg <= maj;
        end
    end

    assign filt = filt_reg;
`else
    assign filt = therm_s_reg;
`endif

    // Highest set bit wins, so a stray low-side bubble cannot lower the code.
    logic [OUT_W-1:0] code;
    always_comb begin
        code = '0;
        for (int i = 0; i < N_LEVELS; i++) begin
            if (filt[i]) begin
                code = OUT_W'(i + 1);
            end
        end
    end

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [RES_W-1:0] acc_reg, acc_next;
    logic [RES_W-1:0] result_reg, result_next;
    logic             valid_reg, valid_next;
    logic             overrun_reg, overrun_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            result_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            result_reg  <= result_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        result_next  = result_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;

        if (valid_reg && res.result_ready) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_SETTLE;
                    cnt_next     = '0;
                    overrun_next = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == CNT_W'(SETTLE_LEN - 1)) begin
                    state_next = ST_ACCUM;
                    cnt_next   = '0;
                    acc_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_ACCUM: begin
                acc_next = acc_reg + RES_W'(code);
                if (cnt_reg == CNT_W'(N_ACC - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                // A result still waiting for the consumer is kept; the new sum is lost.
                if (!valid_reg || res.result_ready) begin
                    result_next = acc_reg;
                    valid_next  = 1'b1;
                end else begin
                    overrun_next = 1'b1;
                end
                if (continuous) begin
                    state_next = ST_ACCUM;
                    cnt_next   = '0;
                    acc_next   = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign res.result       = result_reg;
    assign res.result_valid = valid_reg;
    assign busy             = (state_reg != ST_IDLE);
    assign overrun          = overrun_reg;
endmodule

// File: tb/tb_tiq_therm_encoder.sv
// Bench for tiq_therm_encoder: directed scenarios plus random traffic, checked every cycle
// against a conversion-schedule reference model built on a per-cycle history of therm_in.
module tb_tiq_therm_encoder;
    localparam int N_LEVELS   = 15;
    localparam int OUT_W      = 4;
    localparam int AVG_LOG2   = 2;
    localparam int SETTLE_CYC = 2;
    localparam int RES_W      = OUT_W + AVG_LOG2;
    localparam int N_ACC      = 1 << AVG_LOG2;
`ifdef TIQ_BUBBLE_CORR_EN
    localparam int EXTRA  = 1;
    localparam bit BUBBLE = 1'b1;
`else
    localparam int EXTRA  = 0;
    localparam bit BUBBLE = 1'b0;
`endif
    localparam int DLY        = 2 + EXTRA;
    localparam int SETTLE_LEN = SETTLE_CYC + EXTRA;
    localparam int HIST_N     = 8192;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_LEVELS-1:0] therm_in;
    logic                start;
    logic                continuous;
    logic                busy;
    logic                overrun;

    tiq_therm_encoder_if #(.RES_W(RES_W)) res_if ();

    tiq_therm_encoder #(
        .N_LEVELS  (N_LEVELS),
        .OUT_W     (OUT_W),
        .AVG_LOG2  (AVG_LOG2),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .therm_in  (therm_in),
        .start     (start),
        .continuous(continuous),
        .res       (res_if),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a conversion is a schedule (DONE cycle) plus a window of history samples.
    logic [N_LEVELS-1:0] hist [HIST_N];
    int cyc = 0;
    bit m_busy, m_valid, m_overrun;
    int m_result;
    int t_done;

    function automatic int ref_code(input logic [N_LEVELS-1:0] v);
        int code;
        int n;
        logic [N_LEVELS+1:0] e;
        bit b;
        code = 0;
        e = {1'b0, v, 1'b1};
        for (int i = 0; i < N_LEVELS; i++) begin
            if (BUBBLE) begin
                n = int'(e[i]) + int'(e[i+1]) + int'(e[i+2]);
                b = (n >= 2);
            end else begin
                b = v[i];
            end
            if (b) code = i + 1;
        end
        return code;
    endfunction

    task automatic model_reset();
        m_busy    = 1'b0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_result  = 0;
    endtask

    task automatic model_step();
        bit pre_valid;
        int sum;
        hist[cyc % HIST_N] = therm_in;
        if (rst) begin
            model_reset();
        end else begin
            pre_valid = m_valid;
            if (m_valid && res_if.result_ready) m_valid = 1'b0;
            if (m_busy && cyc == t_done) begin
                sum = 0;
                for (int c = t_done - N_ACC; c < t_done; c++) begin
                    if (c - DLY >= 0) sum += ref_code(hist[(c - DLY) % HIST_N]);
                end
                if (!pre_valid || res_if.result_ready) begin
                    m_result = sum;
                    m_valid  = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
                if (continuous) t_done += N_ACC + 1;
                else m_busy = 1'b0;
            end else if (!m_busy && start) begin
                m_busy    = 1'b1;
                m_overrun = 1'b0;
                t_done    = cyc + SETTLE_LEN + N_ACC + 1;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("busy", 32'(busy), 32'(m_busy));
        check("valid", 32'(res_if.result_valid), 32'(m_valid));
        check("result", 32'(res_if.result), 32'(m_result));
        check("overrun", 32'(overrun), 32'(m_overrun));
    endtask

    // Called right after tick(): reset rises on the following falling edge.
    task automatic do_async_reset();
        #4;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_result", 32'(res_if.result), 32'd0);
        check("rst_valid", 32'(res_if.result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!res_if.result_valid && n < bound);
    endtask

    task automatic go_idle();
        start = 1'b0;
        continuous = 1'b0;
        res_if.result_ready = 1'b1;
        repeat (16) tick();
    endtask

    task automatic single_shot(input string tag, input logic [N_LEVELS-1:0] v, input int exp);
        int n;
        therm_in = v;
        repeat (3) tick();
        res_if.result_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(40, n);
        check({tag, "_lat"}, 32'(n + 1), 32'(8 + EXTRA));
        check({tag, "_val"}, 32'(res_if.result), 32'(exp));
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        res_if.result_ready = 1'b1;
        tick();
        check({tag, "_pulse"}, 32'(res_if.result_valid), 32'd0);
    endtask

    initial begin
        int n;
        int lvl;
        rst = 1'b1;
        therm_in = '0;
        start = 1'b0;
        continuous = 1'b0;
        res_if.result_ready = 1'b0;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        single_shot("t7f", 15'h007F, 28);
        go_idle();
        single_shot("t00", 15'h0000, 0);
        go_idle();
        single_shot("tff", 15'h7FFF, 60);
        go_idle();
        single_shot("bubble", 15'h00BF, BUBBLE ? 28 : 32);
        go_idle();

        // Back-pressure: second result is dropped and flagged.
        therm_in = 15'h000F;
        repeat (3) tick();
        res_if.result_ready = 1'b0;
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(40, n);
        check("ovr_first", 32'(res_if.result), 32'd16);
        repeat (N_ACC + 1) tick();
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_hold", 32'(res_if.result), 32'd16);
        continuous = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("ovr_idle", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);
        go_idle();

        // Step between conversions: each window must see only one level.
        therm_in = 15'h0003;
        repeat (3) tick();
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        therm_in = 15'h01FF;
        repeat (3 + EXTRA) tick();
        check("step_first", 32'(res_if.result), 32'd8);
        check("step_first_v", 32'(res_if.result_valid), 32'd1);
        repeat (N_ACC + 1) tick();
        check("step_second", 32'(res_if.result), 32'd36);
        check("step_second_v", 32'(res_if.result_valid), 32'd1);
        go_idle();

        // Reset in the middle of ACCUM, then a clean conversion.
        therm_in = 15'h7FFF;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4 + EXTRA) tick();
        do_async_reset();
        single_shot("post_rst", 15'h007F, 28);
        go_idle();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    lvl = int'($urandom_range(0, N_LEVELS));
                    therm_in = N_LEVELS'((32'h1 << lvl) - 1);
                end else begin
                    therm_in = N_LEVELS'($urandom);
                end
            end
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) continuous = ~continuous;
            res_if.result_ready = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 299) == 0) do_async_reset();
            else tick();
        end
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tiq_therm_encoder.md
# tiq_therm_encoder

Digital back-end for the TIQ flash ADC: captures the comparator bank's thermometer code, synchronises it into `clk`, optionally bubble-corrects it, encodes it to binary and accumulates 2^AVG_LOG2 samples per conversion. It sits directly downstream of the analog TIQ comparator array inside the tile and presents results on a valid/ready interface to the output/readout logic driving `uo_out`.

## Interface
- `N_LEVELS`, 15: thermometer width, i.e. number of comparators; bit 0 is the lowest threshold.
- `OUT_W`, 4: per-sample code width; must satisfy 2^OUT_W > N_LEVELS.
- `AVG_LOG2`, 2: log2 of samples accumulated per conversion; 0 is legal (single sample).
- `SETTLE_CYC`, 2: discarded cycles after `start`; ≥2, to cover synchroniser latency.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `therm_in`  in  N_LEVELS  raw comparator outputs, asynchronous to `clk`.
- `start`  in  1  begin conversion; sampled only in IDLE.
- `continuous`  in  1  1: re-convert back-to-back after each result.
- `result`  out  OUT_W+AVG_LOG2  sum of encoded samples; registered.
- `result_valid`  out  1  `result` holds an unconsumed conversion.
- `result_ready`  in  1  consumer accepts `result` when valid&&ready.
- `busy`  out  1  state ≠ IDLE.
- `overrun`  out  1  sticky: a completed conversion was dropped.

## Operation
- Synchroniser: two flops on every `therm_in` bit; `therm_s` is the second stage.
- Encoder: code = (index of highest set bit of filtered vector)+1, 0 when no bit set. Range 0..N_LEVELS.
- FSM states:
  - IDLE: `start`=1 → SETTLE, clears `overrun`, clears settle counter.
  - SETTLE: stays SETTLE_CYC cycles, samples ignored → ACCUM.
  - ACCUM: 2^AVG_LOG2 cycles, each adds current code to accumulator (accumulator zeroed on ACCUM entry) → DONE.
  - DONE (1 cycle): commit. If `result_valid`=0 or `result_ready`=1 this cycle, load `result`, set `result_valid`; else drop sum, set `overrun`. Then `continuous`=1 → ACCUM, else IDLE.
- Handshake: `result_valid` falls the cycle after valid&&ready, unless DONE reloads it in that same cycle (stays 1, new data). `result` stable while valid&&!ready.
- Accumulator width OUT_W+AVG_LOG2; cannot overflow (max N_LEVELS·2^AVG_LOG2).
- `start` outside IDLE ignored; `continuous` deasserted mid-conversion takes effect at next DONE.
- Reset (any time, incl. mid-ACCUM): state IDLE; `result`=0, `result_valid`=0, `busy`=0, `overrun`=0; synchroniser and accumulator cleared.

## Timing
- `start` high in IDLE at cycle 0: SETTLE cycles 1..SETTLE_CYC, ACCUM cycles SETTLE_CYC+1..SETTLE_CYC+2^AVG_LOG2, DONE next, `result_valid` high following cycle.
- Defaults: ACCUM 3–6, DONE 7, valid at 8. Continuous: one result per 2^AVG_LOG2+1 cycles.
- `therm_in` to contributing sample: 2 cycles.
- `busy` rises cycle 1, falls cycle after DONE (single-shot).

## Configuration
- `TIQ_BUBBLE_CORR_EN` defined: filtered bit i = majority(therm_s[i-1], therm_s[i], therm_s[i+1]), with therm_s[-1]=1, therm_s[N_LEVELS]=0; adds one pipeline register, so SETTLE lasts SETTLE_CYC+1 and all latencies grow by 1.
- Undefined: filtered vector = `therm_s` directly; no extra register.

## Test plan
- Defaults, `therm_in`=0x007F, single `start` → `result`=28, valid at cycle 8 (9 with macro), `busy` low after DONE.
- `therm_in`=0x0000 → 0; 0x7FFF → 60; `result_ready` tied 1, valid pulses one cycle.
- Bubble `therm_in`=0x00BF → 32 without macro, 28 with `TIQ_BUBBLE_CORR_EN`.
- `continuous`=1, `result_ready`=0, 0x000F → first result 16 held; second DONE sets `overrun`=1, `result` stays 16; next `start` from IDLE clears `overrun`.
- `continuous`=1, `result_ready`=1, step `therm_in` 0x0003→0x01FF at ACCUM start → results 8 then 36 (no mixed sums), every 5 cycles.
- `rst` pulsed mid-ACCUM → all outputs 0 immediately, IDLE; subsequent `start` yields correct full conversion.
